// File: rtl/mux_nway_reg.sv
// rtl/mux_nway_reg.sv - registered N-way channel mux with valid/ready handshake
//
// Selects one of NUM_IN input channels by sel and holds the result in a
// single output register. The register drains and refills in the same cycle,
// so the block sustains one beat per clock.
//
// Parameters
//   WIDTH   data width of each channel and of out_data
//   NUM_IN  number of input channels (2..16)
//   SEL_W   select width, ceil(log2(NUM_IN)) <= SEL_W <= 4
//
// Ports
//   Clk        clock, rising edge
//   Rst        asynchronous active-low reset
//   in_data    packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel        channel select, qualified by in_valid
//   in_valid   upstream beat valid
//   in_ready   block can take a beat this cycle
//   out_data   registered selected data
//   out_sel    registered sel that produced out_data
//   out_valid  out_data/out_sel valid
//   out_ready  downstream takes the output beat
//   sel_err    an out-of-range select was accepted
//
// Build option
//   MUX_STICKY_ERR_EN  when defined, sel_err latches on the first illegal
//                      beat and stays high until reset; otherwise it pulses
//                      for the one cycle the illegal beat first appears.

module mux_nway_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    // One extra bit so NUM_IN = 2**SEL_W (e.g. 16 with SEL_W=4) still fits.
    localparam logic [SEL_W:0] NUM_IN_V = (SEL_W + 1)'(NUM_IN);

    logic             sel_ok;
    logic             accept;
    logic [WIDTH-1:0] mux_data;

    assign sel_ok   = ({1'b0, sel} < NUM_IN_V);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if ({1'b0, sel} == (SEL_W + 1)'(k)) begin
                mux_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_sel   <= sel;
                // An illegal select still produces a beat, but the data
                // register keeps whatever it held before.
                if (sel_ok) begin
                    out_data <= mux_data;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef MUX_STICKY_ERR_EN
            sel_err <= sel_err || (accept && !sel_ok);
`else
            sel_err <= accept && !sel_ok;
`endif
        end
    end

endmodule

// File: tb/tb_mux_nway_reg.sv
// tb/tb_mux_nway_reg.sv - scoreboard bench for mux_nway_reg

module tb_mux_nway_reg;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  sel;
        logic        err;
    } exp_t;

    logic        Clk;
    logic        Rst;

    // instance a: default parameters
    logic [95:0] in_data_a;
    logic [1:0]  sel_a;
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, sel_err_a;
    logic [31:0] out_data_a;
    logic [1:0]  out_sel_a;

    // instance b: NUM_IN=5, WIDTH=8, SEL_W=3
    logic [39:0] in_data_b;
    logic [2:0]  sel_b;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, sel_err_b;
    logic [7:0]  out_data_b;
    logic [2:0]  out_sel_b;

    int n_cmp;
    int n_bad;

    exp_t qa[$];
    exp_t qb[$];
    exp_t held[2];
    logic hv[2];
    logic [31:0] last[2];
    logic seen[2];

    mux_nway_reg u_a (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_data   (in_data_a),
        .sel       (sel_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out_data  (out_data_a),
        .out_sel   (out_sel_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .sel_err   (sel_err_a)
    );

    mux_nway_reg #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) u_b (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_data   (in_data_b),
        .sel       (sel_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out_data  (out_data_b),
        .out_sel   (out_sel_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .sel_err   (sel_err_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] chan_val(input int inst, input int s);
        if (inst == 0) return 32'h11 * 32'(s + 1);
        return 32'hA0 + 32'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hv[i]   = 1'b0;
            held[i] = '{data: 32'h0, sel: 4'h0, err: 1'b0};
            last[i] = 32'h0;
            seen[i] = 1'b0;
        end
        qa.delete();
        qb.delete();
    endtask

    // Called at a falling edge: drive one cycle of stimulus, check in_ready,
    // then check the outputs at the next falling edge.
    task automatic step(input int inst, input logic v, input int s, input logic ordy);
        exp_t        e;
        logic        rdy_exp, acc, ill, err_exp;
        logic        g_rdy, g_vld, g_err;
        logic [31:0] g_data, g_sel;
        string       nm;
        nm = (inst == 0) ? "a" : "b";
        if (inst == 0) begin
            in_valid_a = v; sel_a = 2'(s); out_ready_a = ordy;
        end else begin
            in_valid_b = v; sel_b = 3'(s); out_ready_b = ordy;
        end
        #1;
        g_rdy   = (inst == 0) ? in_ready_a : in_ready_b;
        rdy_exp = !hv[inst] || ordy;
        check_eq({nm, "_in_ready"}, 32'(g_rdy), 32'(rdy_exp));
        acc = v && rdy_exp;
        ill = 1'b0;
        if (acc) begin
            ill = (s >= ((inst == 0) ? 3 : 5));
            if (!ill) last[inst] = chan_val(inst, s);
            if (ill) seen[inst] = 1'b1;
            e.data = last[inst];
            e.sel  = 4'(s);
`ifdef MUX_STICKY_ERR_EN
            e.err  = seen[inst];
`else
            e.err  = ill;
`endif
            if (inst == 0) qa.push_back(e); else qb.push_back(e);
        end
        @(posedge Clk);
        @(negedge Clk);
        if (acc) begin
            if (inst == 0) e = qa.pop_front(); else e = qb.pop_front();
            held[inst] = e;
            hv[inst]   = 1'b1;
            err_exp    = e.err;
        end else begin
            if (hv[inst] && ordy) hv[inst] = 1'b0;
`ifdef MUX_STICKY_ERR_EN
            err_exp = seen[inst];
`else
            err_exp = 1'b0;
`endif
        end
        g_vld  = (inst == 0) ? out_valid_a : out_valid_b;
        g_err  = (inst == 0) ? sel_err_a : sel_err_b;
        g_data = (inst == 0) ? out_data_a : 32'(out_data_b);
        g_sel  = (inst == 0) ? 32'(out_sel_a) : 32'(out_sel_b);
        check_eq({nm, "_out_valid"}, 32'(g_vld), 32'(hv[inst]));
        check_eq({nm, "_out_data"}, g_data, held[inst].data);
        check_eq({nm, "_out_sel"}, g_sel, 32'(held[inst].sel));
        check_eq({nm, "_sel_err"}, 32'(g_err), 32'(err_exp));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        Rst = 1'b0;
        in_data_a = {32'h33, 32'h22, 32'h11};
        in_data_b = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
        sel_a = 2'd0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        sel_b = 3'd0; in_valid_b = 1'b0; out_ready_b = 1'b1;

        repeat (2) @(negedge Clk);
        check_eq("rst_out_valid", 32'(out_valid_a), 32'h0);
        check_eq("rst_out_data", out_data_a, 32'h0);
        check_eq("rst_out_sel", 32'(out_sel_a), 32'h0);
        check_eq("rst_sel_err", 32'(sel_err_a), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready_a), 32'h1);
        Rst = 1'b1;
        @(negedge Clk);

        // single beat, sel=1
        step(0, 1'b1, 1, 1'b1);
        // back-to-back 0,1,2 with no bubble
        step(0, 1'b1, 0, 1'b1);
        step(0, 1'b1, 1, 1'b1);
        step(0, 1'b1, 2, 1'b1);
        // drain
        step(0, 1'b0, 0, 1'b1);
        // stall: sel=2 accepted, three blocked cycles, then release
        step(0, 1'b1, 2, 1'b1);
        repeat (3) step(0, 1'b1, 0, 1'b0);
        step(0, 1'b1, 0, 1'b1);
        step(0, 1'b0, 0, 1'b1);
        // illegal select after 0x22
        step(0, 1'b1, 1, 1'b1);
        step(0, 1'b1, 3, 1'b1);
        step(0, 1'b1, 3, 1'b1);
        step(0, 1'b0, 0, 1'b0);
        step(0, 1'b0, 1, 1'b1);
        // random traffic
        for (int i = 0; i < 30; i++) begin
            step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        // asynchronous reset mid-cycle while a beat is held
        step(0, 1'b0, 0, 1'b1);
        step(0, 1'b1, 3, 1'b0);
        #2 Rst = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid_a), 32'h0);
        check_eq("arst_out_data", out_data_a, 32'h0);
        check_eq("arst_out_sel", 32'(out_sel_a), 32'h0);
        check_eq("arst_sel_err", 32'(sel_err_a), 32'h0);
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
        #1;
        check_eq("arst_in_ready", 32'(in_ready_a), 32'h1);
        @(negedge Clk);
        step(0, 1'b1, 2, 1'b1);
        step(0, 1'b0, 0, 1'b1);

        // five-channel instance: legal top channel then every illegal code
        step(1, 1'b1, 4, 1'b1);
        step(1, 1'b1, 5, 1'b1);
        step(1, 1'b1, 6, 1'b1);
        step(1, 1'b1, 7, 1'b1);
        step(1, 1'b1, 2, 1'b1);
        step(1, 1'b0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_nway_reg.md
MUX_NWAY_REG -- requirements
Module: mux_nway_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of each input and of the output.
REQ-002 SHALL have parameter NUM_IN, default 3, the number of input channels; legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2, the select width; ceil(log2(NUM_IN)) <= SEL_W <= 4.
REQ-004 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_data, input, NUM_IN*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel, input, SEL_W bits: channel select, qualified by in_valid.
REQ-008 SHALL have port in_valid, input, 1 bit: the upstream beat (in_data, sel) is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-010 SHALL have port out_data, output, WIDTH bits: the registered selected data.
REQ-011 SHALL have port out_sel, output, SEL_W bits: the registered copy of the sel that produced out_data.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data and out_sel are valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-014 SHALL have port sel_err, output, 1 bit: an illegal select was accepted.

Function
REQ-015 SHALL implement a 1-entry output register; in_ready = !out_valid || out_ready, purely combinational and with no dependency on in_valid.
REQ-016 SHALL accept a beat when in_valid && in_ready; the beat's data SHALL appear on out_data with out_valid=1 exactly 1 cycle later (latency 1).
REQ-017 SHALL, on an accepted beat with sel < NUM_IN, load out_data with channel sel and load out_sel with sel.
REQ-018 SHALL treat sel >= NUM_IN as illegal; the beat SHALL still be accepted and out_valid set, out_data SHALL hold its previous value, and out_sel SHALL load the illegal sel.
REQ-019 SHALL, when out_valid && out_ready && !in_valid, clear out_valid on the next edge and leave out_data/out_sel unchanged.
REQ-020 SHALL, when out_valid && out_ready && in_valid in the same cycle, replace the output with the new beat with no bubble (full throughput, 1 beat/cycle).
REQ-021 SHALL, when out_valid && !out_ready, hold out_data, out_sel and out_valid stable and keep in_ready=0.
REQ-022 SHALL ignore in_data and sel whenever in_valid=0 or in_ready=0.
REQ-023 SHALL pulse sel_err high for exactly the cycle after an illegal beat is accepted (the cycle in which that beat is first presented on the output), unless MUX_STICKY_ERR_EN is defined.

Reset
REQ-024 SHALL, while Rst=0, asynchronously force out_valid=0, out_data=0, out_sel=0 and sel_err=0.
REQ-025 SHALL discard any beat held in the output register if Rst asserts mid-transfer; after Rst rises, in_ready=1 and the first accepted beat behaves per REQ-016.

Configuration
REQ-026 SHALL use macro MUX_STICKY_ERR_EN: when it is defined, sel_err sets on the first accepted illegal beat and stays high until reset; when it is undefined, sel_err behaves per REQ-023.

Verification
REQ-027 Default parameters, ch0=0x11, ch1=0x22, ch2=0x33, out_ready=1, in_valid=1, sel=1 -> next cycle out_data=0x22, out_sel=1, out_valid=1.
REQ-028 Back-to-back sel=0,1,2 with out_ready=1 -> out_data is 0x11, 0x22, 0x33 on 3 consecutive cycles, with no bubble and in_ready continuously 1.
REQ-029 Beat sel=2 accepted, then out_ready=0 for 3 cycles with in_valid=1, sel=0 -> out_data stays 0x33, in_ready=0; out_ready=1 -> 0x11 follows one cycle later.
REQ-030 After out_data=0x22, accept sel=3 -> out_data stays 0x22, out_sel=3 and sel_err=1 for 1 cycle (stays 1 with MUX_STICKY_ERR_EN defined).
REQ-031 Assert Rst=0 mid-cycle while out_valid=1 -> out_valid, out_data and sel_err are 0 immediately without a clock edge; after release, in_ready=1.
REQ-032 NUM_IN=5, WIDTH=8, SEL_W=3, sel=4 -> channel 4 is selected; sel=5, 6 and 7 -> each flagged per REQ-018.
